// File: rtl/lemmings_activity_monitor.sv
// lemmings_activity_monitor
//
// Watches the five activity outputs of the Lemmings behaviour FSM, decodes
// them into a single activity code and keeps running statistics for the
// debug/status readout: cycles spent walking, entries into fall/dig/jump,
// direct walking turnarounds, the longest completed fall and two sticky
// flags (splat after an over-long fall, illegal after a multi-hot vector).
//
// Pipeline: stage 1 registers the raw vector, stage 2 decodes it and updates
// every output, so outputs trail the inputs by two clocks.
//
// Optional build macro: LEMM_MON_SATURATE_EN
//   defined   -> every CNT_W counter saturates at all-ones
//   undefined -> every CNT_W counter wraps modulo 2^CNT_W
//
// Ports
//   clk            system clock, rising edge
//   areset         asynchronous reset, active low
//   walk_left, walk_right, aah, digging, jumping   FSM activity outputs
//   clr            synchronous clear of statistics and flags
//   activity_code  decoded activity (0 none,1 wl,2 wr,3 fall,4 dig,5 jump,7 multi)
//   event_valid    one-cycle pulse when the decoded activity changes
//   walk_l_cyc, walk_r_cyc        cycles walking left / right
//   fall_cnt, dig_cnt, jump_cnt   entries into fall / dig / jump
//   turn_cnt       direct walk_left <-> walk_right transitions
//   fall_len_max   longest completed fall, in cycles
//   splat          sticky: a completed fall was longer than SPLAT_CYCLES
//   illegal        sticky: a multi-hot vector was seen

module lemmings_activity_monitor #(
  parameter int CNT_W        = 16,
  parameter int FL_W         = 8,
  parameter int SPLAT_CYCLES = 20
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             walk_left,
  input  logic             walk_right,
  input  logic             aah,
  input  logic             digging,
  input  logic             jumping,
  input  logic             clr,
  output logic [2:0]       activity_code,
  output logic             event_valid,
  output logic [CNT_W-1:0] walk_l_cyc,
  output logic [CNT_W-1:0] walk_r_cyc,
  output logic [CNT_W-1:0] fall_cnt,
  output logic [CNT_W-1:0] dig_cnt,
  output logic [CNT_W-1:0] jump_cnt,
  output logic [CNT_W-1:0] turn_cnt,
  output logic [FL_W-1:0]  fall_len_max,
  output logic             splat,
  output logic             illegal
);

  typedef enum logic [2:0] {
    ACT_NONE   = 3'd0,
    ACT_WALK_L = 3'd1,
    ACT_WALK_R = 3'd2,
    ACT_FALL   = 3'd3,
    ACT_DIG    = 3'd4,
    ACT_JUMP   = 3'd5,
    ACT_MULTI  = 3'd7
  } act_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [FL_W-1:0]  FL_ZERO   = {FL_W{1'b0}};
  localparam logic [FL_W-1:0]  FL_ONE    = {{(FL_W-1){1'b0}}, 1'b1};
  localparam logic [FL_W-1:0]  FL_MAX    = {FL_W{1'b1}};
  localparam logic [FL_W-1:0]  SPLAT_LIM = FL_W'(SPLAT_CYCLES);

  // Statistic counter increment: wraps by default, saturates when enabled.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
`ifdef LEMM_MON_SATURATE_EN
    if (v == {CNT_W{1'b1}}) begin
      cnt_inc = v;
    end else begin
      cnt_inc = v + CNT_ONE;
    end
`else
    cnt_inc = v + CNT_ONE;
`endif
  endfunction

  logic [4:0]       sample;
  act_t             prev_act;
  act_t             cur_act;
  logic [FL_W-1:0]  fall_timer;

  act_t             prev_act_nxt;
  logic             event_nxt;
  logic [CNT_W-1:0] walk_l_nxt, walk_r_nxt, fall_cnt_nxt;
  logic [CNT_W-1:0] dig_cnt_nxt, jump_cnt_nxt, turn_cnt_nxt;
  logic [FL_W-1:0]  fall_timer_nxt, fall_len_max_nxt;
  logic             splat_nxt, illegal_nxt;
  logic             change, fall_exit, turn;

  // Stage 1: capture the raw activity vector.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      sample <= 5'd0;
    end else begin
      sample <= {walk_left, walk_right, aah, digging, jumping};
    end
  end

  // Decode the captured vector: one-hot gives its activity, zero is none,
  // anything with two or more bits set is multi.
  always_comb begin
    cur_act = ACT_MULTI;
    case (sample)
      5'b00000: cur_act = ACT_NONE;
      5'b10000: cur_act = ACT_WALK_L;
      5'b01000: cur_act = ACT_WALK_R;
      5'b00100: cur_act = ACT_FALL;
      5'b00010: cur_act = ACT_DIG;
      5'b00001: cur_act = ACT_JUMP;
      default:  cur_act = ACT_MULTI;
    endcase
  end

  // Stage 2 next-state: statistics, fall timing and flags; clr overrides all.
  always_comb begin
    change    = (cur_act != prev_act);
    fall_exit = (prev_act == ACT_FALL) && change;
    turn      = ((prev_act == ACT_WALK_L) && (cur_act == ACT_WALK_R)) ||
                ((prev_act == ACT_WALK_R) && (cur_act == ACT_WALK_L));

    prev_act_nxt = cur_act;
    event_nxt    = change;
    walk_l_nxt   = (cur_act == ACT_WALK_L) ? cnt_inc(walk_l_cyc) : walk_l_cyc;
    walk_r_nxt   = (cur_act == ACT_WALK_R) ? cnt_inc(walk_r_cyc) : walk_r_cyc;
    fall_cnt_nxt = ((cur_act == ACT_FALL) && change) ? cnt_inc(fall_cnt) : fall_cnt;
    dig_cnt_nxt  = ((cur_act == ACT_DIG)  && change) ? cnt_inc(dig_cnt)  : dig_cnt;
    jump_cnt_nxt = ((cur_act == ACT_JUMP) && change) ? cnt_inc(jump_cnt) : jump_cnt;
    turn_cnt_nxt = turn ? cnt_inc(turn_cnt) : turn_cnt;
    illegal_nxt  = illegal | (cur_act == ACT_MULTI);

    // The timer counts cycles of the current fall including the entry cycle.
    if (cur_act == ACT_FALL) begin
      if (change) begin
        fall_timer_nxt = FL_ONE;
      end else if (fall_timer == FL_MAX) begin
        fall_timer_nxt = fall_timer;
      end else begin
        fall_timer_nxt = fall_timer + FL_ONE;
      end
    end else begin
      fall_timer_nxt = FL_ZERO;
    end

    fall_len_max_nxt = (fall_exit && (fall_timer > fall_len_max)) ? fall_timer : fall_len_max;
    splat_nxt        = splat | (fall_exit && (fall_timer > SPLAT_LIM));

    // clr discards statistics but keeps tracking the ongoing activity, so it
    // is not re-counted as an entry and a fall is timed from this cycle.
    if (clr) begin
      event_nxt        = 1'b0;
      walk_l_nxt       = CNT_ZERO;
      walk_r_nxt       = CNT_ZERO;
      fall_cnt_nxt     = CNT_ZERO;
      dig_cnt_nxt      = CNT_ZERO;
      jump_cnt_nxt     = CNT_ZERO;
      turn_cnt_nxt     = CNT_ZERO;
      fall_len_max_nxt = FL_ZERO;
      splat_nxt        = 1'b0;
      illegal_nxt      = 1'b0;
      fall_timer_nxt   = (cur_act == ACT_FALL) ? FL_ONE : FL_ZERO;
    end else begin
      event_nxt        = change;
    end
  end

  // Stage 2 state and output registers.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      prev_act     <= ACT_NONE;
      event_valid  <= 1'b0;
      walk_l_cyc   <= CNT_ZERO;
      walk_r_cyc   <= CNT_ZERO;
      fall_cnt     <= CNT_ZERO;
      dig_cnt      <= CNT_ZERO;
      jump_cnt     <= CNT_ZERO;
      turn_cnt     <= CNT_ZERO;
      fall_timer   <= FL_ZERO;
      fall_len_max <= FL_ZERO;
      splat        <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      prev_act     <= prev_act_nxt;
      event_valid  <= event_nxt;
      walk_l_cyc   <= walk_l_nxt;
      walk_r_cyc   <= walk_r_nxt;
      fall_cnt     <= fall_cnt_nxt;
      dig_cnt      <= dig_cnt_nxt;
      jump_cnt     <= jump_cnt_nxt;
      turn_cnt     <= turn_cnt_nxt;
      fall_timer   <= fall_timer_nxt;
      fall_len_max <= fall_len_max_nxt;
      splat        <= splat_nxt;
      illegal      <= illegal_nxt;
    end
  end

  // The previous-activity register is also the registered activity output.
  assign activity_code = prev_act;

endmodule

// File: tb/tb_lemmings_activity_monitor.sv
// Testbench for lemmings_activity_monitor (built with CNT_W = 4 so counter
// wrap/saturation is reachable). The driver applies one input vector per
// cycle, runs the reference model and queues the expected outputs; the
// monitor pops one entry per clock edge and compares it to the DUT.
module tb_lemmings_activity_monitor;

  localparam int CW   = 4;
  localparam int FW   = 8;
  localparam int SPL  = 20;
  localparam int CMAX = (1 << CW) - 1;
  localparam int FMAX = (1 << FW) - 1;

  localparam logic [4:0] V_WL  = 5'b10000;
  localparam logic [4:0] V_WR  = 5'b01000;
  localparam logic [4:0] V_AAH = 5'b00100;
  localparam logic [4:0] V_DIG = 5'b00010;
  localparam logic [4:0] V_NO  = 5'b00000;

  logic          clk = 1'b0;
  logic          areset = 1'b0;
  logic          walk_left = 1'b0, walk_right = 1'b0, aah = 1'b0, digging = 1'b0, jumping = 1'b0;
  logic          clr = 1'b0;
  logic [2:0]    activity_code;
  logic          event_valid;
  logic [CW-1:0] walk_l_cyc, walk_r_cyc, fall_cnt, dig_cnt, jump_cnt, turn_cnt;
  logic [FW-1:0] fall_len_max;
  logic          splat, illegal;

  lemmings_activity_monitor #(.CNT_W(CW), .FL_W(FW), .SPLAT_CYCLES(SPL)) dut (
    .clk(clk), .areset(areset),
    .walk_left(walk_left), .walk_right(walk_right), .aah(aah),
    .digging(digging), .jumping(jumping), .clr(clr),
    .activity_code(activity_code), .event_valid(event_valid),
    .walk_l_cyc(walk_l_cyc), .walk_r_cyc(walk_r_cyc),
    .fall_cnt(fall_cnt), .dig_cnt(dig_cnt), .jump_cnt(jump_cnt),
    .turn_cnt(turn_cnt), .fall_len_max(fall_len_max),
    .splat(splat), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int code, ev, wl, wr, fc, dc, jc, tc, flm, sp, il;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   pulses = 0;

  // reference model state (integers, stats kept modulo / clamped at CMAX)
  logic [4:0] m_sample;
  int m_prev, m_flen;
  exp_t m;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int decode(input logic [4:0] v);
    int n;
    n = $countones(v);
    if (n == 0) return 0;
    if (n > 1) return 7;
    for (int i = 0; i < 5; i++) if (v[i]) return 5 - i;
    return 0;
  endfunction

  function automatic int bump(input int c);
`ifdef LEMM_MON_SATURATE_EN
    return (c < CMAX) ? c + 1 : CMAX;
`else
    return (c + 1) % (CMAX + 1);
`endif
  endfunction

  task automatic model_reset();
    m_sample = 5'd0;
    m_prev = 0;
    m_flen = 0;
    m = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  endtask

  // one clock edge of the reference model: stage 2 uses the previous sample
  task automatic model_step(input logic [4:0] v, input logic c);
    int cur;
    bit changed;
    cur = decode(m_sample);
    changed = (cur != m_prev);
    if (c) begin
      m = '{cur, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      m_flen = (cur == 3) ? 1 : 0;
    end else begin
      m.ev = changed ? 1 : 0;
      if (cur == 1) m.wl = bump(m.wl);
      if (cur == 2) m.wr = bump(m.wr);
      if (changed && cur == 3) m.fc = bump(m.fc);
      if (changed && cur == 4) m.dc = bump(m.dc);
      if (changed && cur == 5) m.jc = bump(m.jc);
      if ((m_prev == 1 && cur == 2) || (m_prev == 2 && cur == 1)) m.tc = bump(m.tc);
      if (cur == 7) m.il = 1;
      if (m_prev == 3 && changed) begin
        if (m_flen > m.flm) m.flm = m_flen;
        if (m_flen > SPL) m.sp = 1;
        m_flen = 0;
      end
      if (cur == 3) m_flen = changed ? 1 : ((m_flen < FMAX) ? m_flen + 1 : FMAX);
      m.code = cur;
    end
    m_prev = cur;
    m_sample = v;
  endtask

  task automatic step(input logic [4:0] v, input logic c = 1'b0);
    @(negedge clk);
    {walk_left, walk_right, aah, digging, jumping} = v;
    clr = c;
    @(posedge clk);
    if (areset) begin
      model_step(v, c);
      q.push_back(m);
    end
  endtask

  task automatic check_all_zero();
    chk("rst_code", int'(activity_code), 0);
    chk("rst_ev", int'(event_valid), 0);
    chk("rst_wl", int'(walk_l_cyc), 0);
    chk("rst_wr", int'(walk_r_cyc), 0);
    chk("rst_fc", int'(fall_cnt), 0);
    chk("rst_dc", int'(dig_cnt), 0);
    chk("rst_jc", int'(jump_cnt), 0);
    chk("rst_tc", int'(turn_cnt), 0);
    chk("rst_flm", int'(fall_len_max), 0);
    chk("rst_splat", int'(splat), 0);
    chk("rst_illegal", int'(illegal), 0);
  endtask

  // asserted between edges so the asynchronous path is what clears outputs
  task automatic do_reset();
    @(negedge clk);
    #2 areset = 1'b0;
    {walk_left, walk_right, aah, digging, jumping} = 5'd0;
    clr = 1'b0;
    #1 check_all_zero();
    model_reset();
    repeat (2) @(negedge clk);
    areset = 1'b1;
  endtask

  // monitor: one expected entry per active edge while out of reset
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("code", int'(activity_code), e.code);
        chk("event_valid", int'(event_valid), e.ev);
        chk("walk_l_cyc", int'(walk_l_cyc), e.wl);
        chk("walk_r_cyc", int'(walk_r_cyc), e.wr);
        chk("fall_cnt", int'(fall_cnt), e.fc);
        chk("dig_cnt", int'(dig_cnt), e.dc);
        chk("jump_cnt", int'(jump_cnt), e.jc);
        chk("turn_cnt", int'(turn_cnt), e.tc);
        chk("fall_len_max", int'(fall_len_max), e.flm);
        chk("splat", int'(splat), e.sp);
        chk("illegal", int'(illegal), e.il);
        if (event_valid) pulses++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] v;
    int dur, r;
    model_reset();
    #1 check_all_zero();
    repeat (2) @(negedge clk);
    areset = 1'b1;

    // walking and turning
    pulses = 0;
    repeat (5) step(V_WL);
    repeat (3) step(V_WR);
    step(V_WL);
    step(V_WL);
    #2;
    chk("dir_walk_l", int'(walk_l_cyc), 6);
    chk("dir_walk_r", int'(walk_r_cyc), 3);
    chk("dir_turn", int'(turn_cnt), 2);
    chk("dir_pulses", pulses, 3);

    // fall of exactly the splat threshold, then one cycle longer
    repeat (20) step(V_AAH);
    step(V_WL); step(V_WL);
    #2;
    chk("dir_fall_cnt20", int'(fall_cnt), 1);
    chk("dir_flm20", int'(fall_len_max), 20);
    chk("dir_splat20", int'(splat), 0);
    repeat (21) step(V_AAH);
    step(V_WL); step(V_WL);
    #2;
    chk("dir_flm21", int'(fall_len_max), 21);
    chk("dir_splat21", int'(splat), 1);

    // multi-hot vector
    step(V_WL | V_DIG); step(V_WL);
    #2;
    chk("dir_multi_code", int'(activity_code), 7);
    chk("dir_illegal", int'(illegal), 1);
    step(V_WL);
    #2;
    chk("dir_illegal_sticky", int'(illegal), 1);

    // clr in the middle of a dig, then a fresh dig entry
    repeat (4) step(V_DIG);
    step(V_DIG, 1'b1);
    repeat (5) step(V_DIG);
    #2;
    chk("dir_dig_after_clr", int'(dig_cnt), 0);
    step(V_WL); step(V_WL); step(V_DIG); step(V_DIG);
    #2;
    chk("dir_dig_reentry", int'(dig_cnt), 1);

    // reset during a fall discards it
    repeat (15) step(V_AAH);
    do_reset();
    repeat (5) step(V_AAH);
    step(V_WL); step(V_WL);
    #2;
    chk("dir_rst_fall_cnt", int'(fall_cnt), 1);
    chk("dir_rst_flm", int'(fall_len_max), 5);
    chk("dir_rst_splat", int'(splat), 0);

    // counter wrap / saturation
    do_reset();
    repeat (18) step(V_WR);
    #2;
`ifdef LEMM_MON_SATURATE_EN
    chk("dir_wr_sat", int'(walk_r_cyc), 15);
`else
    chk("dir_wr_wrap", int'(walk_r_cyc), 1);
`endif

    // randomized segments with occasional clr and resets
    do_reset();
    for (int seg = 0; seg < 250; seg++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        v = V_NO;
        v[$urandom_range(0, 4)] = 1'b1;
      end else if (r < 80) begin
        v = V_NO;
      end else begin
        do v = 5'($urandom_range(0, 31)); while ($countones(v) < 2);
      end
      dur = (r < 85) ? $urandom_range(1, 30) : 1;
      for (int k = 0; k < dur; k++) step(v, ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
      if (seg % 80 == 79) do_reset();
    end
    step(V_NO); step(V_NO);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
